// File: rtl/trace_pkt_serializer.sv
// Buffers 3-slot retire packets and emits one registered record per valid slot.
// Output registers are loaded from the post-edge FIFO state, so nothing combinational reaches out_*.
module trace_pkt_serializer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  in_valid_ip,
  input  logic [95:0] in_insn_ip,
  input  logic [95:0] in_address_ip,
  input  logic [2:0]  in_exception_ip,
  input  logic [2:0]  in_interrupt_ip,
  input  logic [4:0]  in_ecause_ip,
  input  logic [31:0] in_tval_ip,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_addr,
  output logic        out_exc,
  output logic        out_intr,
  output logic [4:0]  out_ecause,
  output logic [31:0] out_tval,
  output logic        ovf,
  output logic [7:0]  drop_cnt,
  input  logic        ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [2:0]  r_mem_valid  [DEPTH];
  logic [95:0] r_mem_insn   [DEPTH];
  logic [95:0] r_mem_addr   [DEPTH];
  logic [2:0]  r_mem_exc    [DEPTH];
  logic [2:0]  r_mem_intr   [DEPTH];
  logic [4:0]  r_mem_ecause [DEPTH];
  logic [31:0] r_mem_tval   [DEPTH];

  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_head_mask;

  logic        r_out_valid, r_out_exc, r_out_intr, r_ovf;
  logic [31:0] r_out_insn, r_out_addr, r_out_tval;
  logic [4:0]  r_out_ecause;
  logic [7:0]  r_drop_cnt;

  logic          w_xfer, w_pop, w_full, w_push, w_drop, w_bypass;
  logic [2:0]    w_mask_after, w_mask_next;
  logic [CW-1:0] w_cnt_after_pop, w_cnt_next;
  logic [PW-1:0] w_rd_next;

  logic [2:0]  w_nh_valid, w_nh_exc, w_nh_intr;
  logic [95:0] w_nh_insn, w_nh_addr;
  logic [4:0]  w_nh_ecause;
  logic [31:0] w_nh_tval;

  logic        w_nx_exc, w_nx_intr;
  logic [31:0] w_nx_insn, w_nx_addr, w_nx_tval;
  logic [4:0]  w_nx_ecause;

  always_comb begin
    w_xfer          = r_out_valid & out_ready;
    w_mask_after    = w_xfer ? (r_head_mask & (r_head_mask - 3'd1)) : r_head_mask;
    w_pop           = w_xfer & (w_mask_after == 3'b000);
    w_full          = (r_count == FULL_CNT);
    w_push          = (|in_valid_ip) & (~w_full | w_pop);
    w_drop          = (|in_valid_ip) & w_full & ~w_pop;
    w_cnt_after_pop = r_count - CW'(w_pop);
    w_cnt_next      = w_cnt_after_pop + CW'(w_push);
    w_rd_next       = r_rd_ptr + PW'(w_pop);
    // The incoming packet becomes the head directly when nothing else remains ahead of it.
    w_bypass        = w_push & (w_cnt_after_pop == '0);
  end

  always_comb begin
    if (w_bypass) begin
      w_nh_valid  = in_valid_ip;
      w_nh_insn   = in_insn_ip;
      w_nh_addr   = in_address_ip;
      w_nh_exc    = in_exception_ip;
      w_nh_intr   = in_interrupt_ip;
      w_nh_ecause = in_ecause_ip;
      w_nh_tval   = in_tval_ip;
    end else begin
      w_nh_valid  = r_mem_valid[w_rd_next];
      w_nh_insn   = r_mem_insn[w_rd_next];
      w_nh_addr   = r_mem_addr[w_rd_next];
      w_nh_exc    = r_mem_exc[w_rd_next];
      w_nh_intr   = r_mem_intr[w_rd_next];
      w_nh_ecause = r_mem_ecause[w_rd_next];
      w_nh_tval   = r_mem_tval[w_rd_next];
    end
  end

  always_comb begin
    w_mask_next = 3'b000;
    if (w_cnt_next != '0) begin
      if (w_pop || (r_count == '0)) w_mask_next = w_nh_valid;
      else                          w_mask_next = w_mask_after;
    end
  end

  always_comb begin
    w_nx_insn   = 32'd0;
    w_nx_addr   = 32'd0;
    w_nx_exc    = 1'b0;
    w_nx_intr   = 1'b0;
    w_nx_ecause = 5'd0;
    w_nx_tval   = 32'd0;
    if (w_mask_next[0]) begin
      w_nx_insn = w_nh_insn[31:0];
      w_nx_addr = w_nh_addr[31:0];
      w_nx_exc  = w_nh_exc[0];
      w_nx_intr = w_nh_intr[0];
    end else if (w_mask_next[1]) begin
      w_nx_insn = w_nh_insn[63:32];
      w_nx_addr = w_nh_addr[63:32];
      w_nx_exc  = w_nh_exc[1];
      w_nx_intr = w_nh_intr[1];
    end else if (w_mask_next[2]) begin
      w_nx_insn = w_nh_insn[95:64];
      w_nx_addr = w_nh_addr[95:64];
      w_nx_exc  = w_nh_exc[2];
      w_nx_intr = w_nh_intr[2];
    end
    if (w_nx_exc | w_nx_intr) begin
      w_nx_ecause = w_nh_ecause;
      w_nx_tval   = w_nh_tval;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_valid[r_wr_ptr]  <= in_valid_ip;
      r_mem_insn[r_wr_ptr]   <= in_insn_ip;
      r_mem_addr[r_wr_ptr]   <= in_address_ip;
      r_mem_exc[r_wr_ptr]    <= in_exception_ip;
      r_mem_intr[r_wr_ptr]   <= in_interrupt_ip;
      r_mem_ecause[r_wr_ptr] <= in_ecause_ip;
      r_mem_tval[r_wr_ptr]   <= in_tval_ip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head_mask  <= 3'b000;
      r_out_valid  <= 1'b0;
      r_out_insn   <= 32'd0;
      r_out_addr   <= 32'd0;
      r_out_exc    <= 1'b0;
      r_out_intr   <= 1'b0;
      r_out_ecause <= 5'd0;
      r_out_tval   <= 32'd0;
      r_ovf        <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      r_rd_ptr     <= w_rd_next;
      r_wr_ptr     <= r_wr_ptr + PW'(w_push);
      r_count      <= w_cnt_next;
      r_head_mask  <= w_mask_next;
      r_out_valid  <= (w_mask_next != 3'b000);
      r_out_insn   <= w_nx_insn;
      r_out_addr   <= w_nx_addr;
      r_out_exc    <= w_nx_exc;
      r_out_intr   <= w_nx_intr;
      r_out_ecause <= w_nx_ecause;
      r_out_tval   <= w_nx_tval;
      // A drop on the same edge as a clear wins, restarting the count at one.
      if (w_drop) begin
        r_ovf      <= 1'b1;
        r_drop_cnt <= ovf_clr ? 8'd1 : ((r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1);
      end else if (ovf_clr) begin
        r_ovf      <= 1'b0;
        r_drop_cnt <= 8'd0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_insn   = r_out_insn;
  assign out_addr   = r_out_addr;
  assign out_exc    = r_out_exc;
  assign out_intr   = r_out_intr;
  assign out_ecause = r_out_ecause;
  assign out_tval   = r_out_tval;
  assign ovf        = r_ovf;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_trace_pkt_serializer.sv
// Bench for trace_pkt_serializer: directed vector table, hand sequences for reset and
// drop saturation, then random traffic against a packet-queue reference model.
module tb_trace_pkt_serializer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid_ip = '0;
  logic [95:0] in_insn_ip = '0;
  logic [95:0] in_address_ip = '0;
  logic [2:0]  in_exception_ip = '0;
  logic [2:0]  in_interrupt_ip = '0;
  logic [4:0]  in_ecause_ip = '0;
  logic [31:0] in_tval_ip = '0;
  logic        out_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        out_valid, out_exc, out_intr, ovf;
  logic [31:0] out_insn, out_addr, out_tval;
  logic [4:0]  out_ecause;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  trace_pkt_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid_ip(in_valid_ip), .in_insn_ip(in_insn_ip), .in_address_ip(in_address_ip),
    .in_exception_ip(in_exception_ip), .in_interrupt_ip(in_interrupt_ip),
    .in_ecause_ip(in_ecause_ip), .in_tval_ip(in_tval_ip),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr), .out_exc(out_exc), .out_intr(out_intr),
    .out_ecause(out_ecause), .out_tval(out_tval),
    .ovf(ovf), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of whole packets, each with its set of slots still to send.
  typedef struct {
    logic [2:0]  rem;
    logic [95:0] insn;
    logic [95:0] addr;
    logic [2:0]  exc;
    logic [2:0]  intr;
    logic [4:0]  ec;
    logic [31:0] tv;
  } pkt_t;

  pkt_t q[$];
  int   m_cnt = 0;
  bit   m_ovf = 1'b0;

  function automatic int lowest(input logic [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic model_edge();
    pkt_t p;
    bit   drop;
    if (q.size() > 0 && out_ready) begin
      p = q[0];
      p.rem[lowest(p.rem)] = 1'b0;
      if (p.rem == 3'b000) q.delete(0);
      else q[0] = p;
    end
    drop = 1'b0;
    if (in_valid_ip != 3'b000) begin
      if (q.size() < DEPTH) begin
        p.rem = in_valid_ip; p.insn = in_insn_ip; p.addr = in_address_ip;
        p.exc = in_exception_ip; p.intr = in_interrupt_ip;
        p.ec = in_ecause_ip; p.tv = in_tval_ip;
        q.push_back(p);
      end else drop = 1'b1;
    end
    if (drop) begin
      m_ovf = 1'b1;
      m_cnt = ovf_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (ovf_clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
  endtask

  function automatic logic [102:0] model_rec();
    pkt_t p;
    int   s;
    bit   trap;
    p = q[0];
    s = lowest(p.rem);
    trap = p.exc[s] | p.intr[s];
    return {p.insn[32*s +: 32], p.addr[32*s +: 32], p.exc[s], p.intr[s],
            trap ? p.ec : 5'd0, trap ? p.tv : 32'd0};
  endfunction

  function automatic logic [102:0] act_rec();
    return {out_insn, out_addr, out_exc, out_intr, out_ecause, out_tval};
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(q.size() > 0));
    if (q.size() > 0) chk({tag, "_rec"}, 128'(act_rec()), 128'(model_rec()));
    chk({tag, "_ovf"}, 128'({ovf, drop_cnt}), 128'({m_ovf, 8'(m_cnt)}));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] tag, input logic [7:0] id, input int i);
    return {tag, id, 8'h00, 8'(i)};
  endfunction

  function automatic logic [95:0] mk3(input logic [7:0] tag, input logic [7:0] id);
    return {mk(tag, id, 2), mk(tag, id, 1), mk(tag, id, 0)};
  endfunction

  task automatic drive_id(input logic [2:0] v, input logic [7:0] id, input logic [2:0] exc,
                          input logic rdy, input logic clr);
    in_valid_ip = v; in_insn_ip = mk3(8'hC0, id); in_address_ip = mk3(8'hA0, id);
    in_exception_ip = exc; in_interrupt_ip = 3'b000;
    in_ecause_ip = 5'd2; in_tval_ip = 32'hDEAD;
    out_ready = rdy; ovf_clr = clr;
  endtask

  typedef struct packed {
    logic [2:0] v;
    logic [7:0] id;
    logic [2:0] exc;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] eid;
    logic [1:0] eslot;
    logic       eexc;
    logic       eovf;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[26];
  logic [102:0] exp_rec;

  initial begin
    //          v       id   exc     rdy   clr   ev    eid  slot  exc   ovf   cnt
    tbl[0]  = '{3'b101, 8'd1, 3'b000, 1'b1, 1'b0, 1'b1, 8'd1, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd1, 2'd2, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{3'b010, 8'd2, 3'b010, 1'b1, 1'b0, 1'b1, 8'd2, 2'd1, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{3'b111, 8'd3, 3'b000, 1'b0, 1'b0, 1'b1, 8'd3, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{3'b111, 8'd4, 3'b000, 1'b0, 1'b0, 1'b1, 8'd3, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{3'b111, 8'd5, 3'b000, 1'b0, 1'b0, 1'b1, 8'd3, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[8]  = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd3, 2'd1, 1'b0, 1'b1, 8'd1};
    tbl[9]  = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd3, 2'd2, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd4, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[11] = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd4, 2'd1, 1'b0, 1'b1, 8'd1};
    tbl[12] = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd4, 2'd2, 1'b0, 1'b1, 8'd1};
    tbl[13] = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[14] = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[15] = '{3'b100, 8'd6, 3'b000, 1'b0, 1'b0, 1'b1, 8'd6, 2'd2, 1'b0, 1'b0, 8'd0};
    tbl[16] = '{3'b001, 8'd7, 3'b000, 1'b0, 1'b0, 1'b1, 8'd6, 2'd2, 1'b0, 1'b0, 8'd0};
    tbl[17] = '{3'b011, 8'd8, 3'b000, 1'b1, 1'b0, 1'b1, 8'd7, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[18] = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd8, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[19] = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b1, 8'd8, 2'd1, 1'b0, 1'b0, 8'd0};
    tbl[20] = '{3'b000, 8'd0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[21] = '{3'b111, 8'd9, 3'b000, 1'b0, 1'b0, 1'b1, 8'd9, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[22] = '{3'b111, 8'd10, 3'b000, 1'b0, 1'b0, 1'b1, 8'd9, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[23] = '{3'b111, 8'd11, 3'b000, 1'b0, 1'b0, 1'b1, 8'd9, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[24] = '{3'b111, 8'd12, 3'b000, 1'b0, 1'b1, 1'b1, 8'd9, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[25] = '{3'b111, 8'd13, 3'b000, 1'b0, 1'b0, 1'b1, 8'd9, 2'd0, 1'b0, 1'b1, 8'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", 128'(act_rec()), 128'(0));
    chk("rst_ovf", 128'({ovf, drop_cnt}), 128'(0));
    rst = 1'b0;

    // Directed vector table
    for (int r = 0; r < 26; r++) begin
      drive_id(tbl[r].v, tbl[r].id, tbl[r].exc, tbl[r].rdy, tbl[r].clr);
      step();
      chk($sformatf("tbl%0d_valid", r), 128'(out_valid), 128'(tbl[r].ev));
      if (tbl[r].ev) begin
        exp_rec = {mk(8'hC0, tbl[r].eid, int'(tbl[r].eslot)), mk(8'hA0, tbl[r].eid, int'(tbl[r].eslot)),
                   tbl[r].eexc, 1'b0, tbl[r].eexc ? 5'd2 : 5'd0, tbl[r].eexc ? 32'hDEAD : 32'd0};
        chk($sformatf("tbl%0d_rec", r), 128'(act_rec()), 128'(exp_rec));
      end
      chk($sformatf("tbl%0d_ovf", r), 128'({ovf, drop_cnt}), 128'({tbl[r].eovf, tbl[r].ecnt}));
    end

    // Reset while a record is stalled: output drops immediately, nothing reappears
    drive_id(3'b000, 8'd0, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_data", 128'(act_rec()), 128'(0));
    chk("midrst_ovf", 128'({ovf, drop_cnt}), 128'(0));
    q.delete(); m_ovf = 1'b0; m_cnt = 0;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_idle", 128'(out_valid), 128'(0));
    end
    drive_id(3'b001, 8'd20, 3'b000, 1'b0, 1'b0);
    step();
    chk("postrst_push_v", 128'(out_valid), 128'(1));
    chk("postrst_push_d", 128'(out_insn), 128'(mk(8'hC0, 8'd20, 0)));

    // Fill, then 300 drops: counter must saturate
    drive_id(3'b111, 8'd21, 3'b000, 1'b0, 1'b0);
    step();
    check_model("fill");
    for (int i = 0; i < 300; i++) begin
      drive_id(3'b111, 8'(i), 3'b000, 1'b0, 1'b0);
      step();
      check_model("drop");
    end
    chk("sat_cnt", 128'({ovf, drop_cnt}), 128'({1'b1, 8'hFF}));
    drive_id(3'b000, 8'd0, 3'b000, 1'b0, 1'b1);
    step();
    chk("clr_cnt", 128'({ovf, drop_cnt}), 128'(0));
    check_model("clr");

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_valid_ip     = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      in_insn_ip      = {$urandom, $urandom, $urandom};
      in_address_ip   = {$urandom, $urandom, $urandom};
      in_exception_ip = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      in_interrupt_ip = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      in_ecause_ip    = 5'($urandom);
      in_tval_ip      = $urandom;
      out_ready       = ($urandom_range(0, 3) != 0);
      ovf_clr         = ($urandom_range(0, 49) == 0);
      step();
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
